// File: rtl/optical_pkg.sv
// Shared types and helpers for the optical slot scheduler.
// State encoding, default geometry, switch-cell constants and a field-slice helper.
package optical_pkg;

    localparam int DEF_DSTWIDTH = 3;
    localparam int DEF_PORTNUM  = 8;

    localparam logic SW_BAR   = 1'b0;
    localparam logic SW_CROSS = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MATCH    = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_GNT = 3'd3,
        ST_SETTLE   = 3'd4,
        ST_SLOT     = 3'd5,
        ST_END      = 3'd6
    } state_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Extracts destination field idx from a packed per-port vector of default geometry.
    function automatic logic [DEF_DSTWIDTH-1:0] get_field(
        input logic [DEF_DSTWIDTH*DEF_PORTNUM-1:0] vec,
        input int unsigned                          idx
    );
        return vec[DEF_DSTWIDTH*idx +: DEF_DSTWIDTH];
    endfunction

endpackage

// File: rtl/optical_rr_matcher.sv
// Sequential rotating-priority matcher: examines one port per step, starting at rr_ptr,
// and builds a conflict-free destination permutation from a captured request snapshot.
module optical_rr_matcher
    import optical_pkg::*;
#(
    parameter int P_DSTWIDTH = DEF_DSTWIDTH,
    parameter int P_PORTNUM  = DEF_PORTNUM
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            step,
    input  logic [P_PORTNUM-1:0]            req_in,
    input  logic [P_DSTWIDTH*P_PORTNUM-1:0] dst_in,
    input  logic [P_DSTWIDTH-1:0]           rr_ptr,
    output logic [P_PORTNUM-1:0]            match,
    output logic [P_DSTWIDTH*P_PORTNUM-1:0] req_out,
    output logic                            last
);

    logic [P_PORTNUM-1:0]            snap_req;
    logic [P_DSTWIDTH*P_PORTNUM-1:0] snap_dst;
    logic [P_PORTNUM-1:0]            dst_used;
    logic [P_DSTWIDTH-1:0]           k;
    logic [P_DSTWIDTH-1:0]           cur_port;
    logic [P_DSTWIDTH-1:0]           cur_dst;
    logic                            cur_ok;

    // Port count is a power of two, so the natural wrap of the add gives the modulo.
    assign cur_port = rr_ptr + k;
    assign cur_dst  = snap_dst[cur_port*P_DSTWIDTH +: P_DSTWIDTH];
    assign cur_ok   = step && snap_req[cur_port] && !dst_used[cur_dst];
    assign last     = step && (k == P_DSTWIDTH'(P_PORTNUM-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_req <= '0;
            snap_dst <= '0;
            dst_used <= '0;
            match    <= '0;
            req_out  <= '0;
            k        <= '0;
        end else if (start) begin
            snap_req <= req_in;
            snap_dst <= dst_in;
            dst_used <= '0;
            match    <= '0;
            req_out  <= '0;
            k        <= '0;
        end else if (step) begin
            if (cur_ok) begin
                match[cur_port]                              <= 1'b1;
                dst_used[cur_dst]                            <= 1'b1;
                req_out[cur_port*P_DSTWIDTH +: P_DSTWIDTH]   <= cur_dst;
            end
            if (!last) begin
                k <= k + 1'b1;
            end
        end
    end

endmodule

// File: rtl/optical_slot_scheduler.sv
// Round-based scheduler sharing the 8x8 optical switch among source ports.
// Define OPTICAL_GRANT_TIMEOUT_EN to abort a round when the controller never grants.
module optical_slot_scheduler
    import optical_pkg::*;
#(
    parameter int P_DSTWIDTH    = DEF_DSTWIDTH,
    parameter int P_PORTNUM     = DEF_PORTNUM,
    parameter int P_SETTLE_CYC  = 16,
    parameter int P_SLOT_CYC    = 256,
    parameter int P_TIMEOUT_CYC = 1024
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [P_PORTNUM-1:0]            i_port_req,
    input  logic [P_DSTWIDTH*P_PORTNUM-1:0] i_port_dst,
    output logic [P_DSTWIDTH*P_PORTNUM-1:0] o_8x8out_req,
    output logic                            o_8x8out_valid,
    input  logic                            i_grant_valid,
    output logic                            o_config_end,
    output logic [P_PORTNUM-1:0]            o_port_grant,
    output logic                            o_slot_active,
    output logic                            o_timeout_err
);

    localparam int CNT_MAX = max_of(max_of(P_SETTLE_CYC, P_SLOT_CYC), P_TIMEOUT_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(P_SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LOAD   = CNT_W'(P_SLOT_CYC - 1);

    state_t                  state;
    state_t                  next_state;
    logic [CNT_W-1:0]        cnt;
    logic [P_DSTWIDTH-1:0]   rr_ptr;
    logic                    capture;
    logic                    step_en;
    logic                    match_last;
    logic [P_PORTNUM-1:0]    match_vec;
    logic                    timeout_hit;

    assign capture = (state == ST_IDLE) && (|i_port_req);
    assign step_en = (state == ST_MATCH);

    optical_rr_matcher #(
        .P_DSTWIDTH (P_DSTWIDTH),
        .P_PORTNUM  (P_PORTNUM)
    ) u_matcher (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .start   (capture),
        .step    (step_en),
        .req_in  (i_port_req),
        .dst_in  (i_port_dst),
        .rr_ptr  (rr_ptr),
        .match   (match_vec),
        .req_out (o_8x8out_req),
        .last    (match_last)
    );

`ifdef OPTICAL_GRANT_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_err_q;

    assign timeout_hit = (state == ST_WAIT_GNT) && !i_grant_valid &&
                         (wait_cnt == CNT_W'(P_TIMEOUT_CYC - 1));

    // Counts grant-wait cycles; the error flag is registered so it pulses in the first IDLE cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wait_cnt      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= timeout_hit;
            if (state != ST_WAIT_GNT) begin
                wait_cnt <= '0;
            end else if (!timeout_hit) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign o_timeout_err = timeout_err_q;
`else
    assign timeout_hit   = 1'b0;
    assign o_timeout_err = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (capture) next_state = ST_MATCH;
            ST_MATCH:    if (match_last) next_state = ST_ISSUE;
            ST_ISSUE:    next_state = i_grant_valid ? ST_SETTLE : ST_WAIT_GNT;
            ST_WAIT_GNT: begin
                if (i_grant_valid) begin
                    next_state = ST_SETTLE;
                end else if (timeout_hit) begin
                    next_state = ST_IDLE;
                end
            end
            ST_SETTLE:   if (cnt == '0) next_state = ST_SLOT;
            ST_SLOT:     if (cnt == '0) next_state = ST_END;
            ST_END:      next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // One down-counter serves both SETTLE and SLOT; it loads on entry and stops at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt    <= '0;
            rr_ptr <= '0;
        end else begin
            if (next_state == ST_SETTLE && state != ST_SETTLE) begin
                cnt <= SETTLE_LOAD;
            end else if (next_state == ST_SLOT && state != ST_SLOT) begin
                cnt <= SLOT_LOAD;
            end else if ((state == ST_SETTLE || state == ST_SLOT) && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (state == ST_END || timeout_hit) begin
                rr_ptr <= rr_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        o_8x8out_valid = 1'b0;
        o_config_end   = 1'b0;
        o_slot_active  = 1'b0;
        o_port_grant   = '0;
        case (state)
            ST_ISSUE: o_8x8out_valid = 1'b1;
            ST_SLOT: begin
                o_slot_active = 1'b1;
                o_port_grant  = match_vec;
            end
            ST_END:   o_config_end = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_optical_slot_scheduler.sv
// Directed table-driven bench for optical_slot_scheduler (default geometry, 16/256 cycle timing).
// Rounds run in order so the rotating pointer advances predictably between table rows.
module tb_optical_slot_scheduler;
    import optical_pkg::*;

    typedef struct {
        string       name;
        logic [7:0]  req;
        logic [23:0] dst;
        int          grant_delay;
        int          abort_at;
        logic [23:0] exp_req;
        logic [7:0]  exp_grant;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [7:0]  i_port_req = '0;
    logic [23:0] i_port_dst = '0;
    logic [23:0] o_8x8out_req;
    logic        o_8x8out_valid;
    logic        i_grant_valid = 1'b0;
    logic        o_config_end;
    logic [7:0]  o_port_grant;
    logic        o_slot_active;
    logic        o_timeout_err;

    int total = 0;
    int bad   = 0;

    vec_t vecs[7];

    optical_slot_scheduler dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_port_req     (i_port_req),
        .i_port_dst     (i_port_dst),
        .o_8x8out_req   (o_8x8out_req),
        .o_8x8out_valid (o_8x8out_valid),
        .i_grant_valid  (i_grant_valid),
        .o_config_end   (o_config_end),
        .o_port_grant   (o_port_grant),
        .o_slot_active  (o_slot_active),
        .o_timeout_err  (o_timeout_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one full round for a table row; optionally resets the DUT partway through SLOT.
    task automatic applyStimulus(input vec_t v);
        int n;
        int slot_len;
        int grant_bad;
        int stray;
        logic [7:0] first_grant;
        logic hold_ok;

        @(negedge i_clk);
        i_port_req = v.req;
        i_port_dst = v.dst;
        @(posedge i_clk);
        #1;
        i_port_req = '0;
        i_port_dst = ~v.dst;
        n = 1;
        while (!o_8x8out_valid && n < 40) begin
            i_grant_valid = (v.grant_delay > 0 && n == 3);
            @(posedge i_clk);
            #1;
            n++;
        end
        i_grant_valid = 1'b0;
        checkOutput({v.name, " latency"}, n, 9);
        checkOutput({v.name, " req_out"}, o_8x8out_req, v.exp_req);
        $display("[TB] %s: field3=%0d", v.name, get_field(o_8x8out_req, 3));

        if (v.grant_delay == 0) begin
            i_grant_valid = 1'b1;
            @(posedge i_clk);
            #1;
            i_grant_valid = 1'b0;
        end else begin
            hold_ok = 1'b1;
            for (int i = 0; i < v.grant_delay; i++) begin
                @(posedge i_clk);
                #1;
                if (o_8x8out_valid || o_slot_active || o_8x8out_req !== v.exp_req) hold_ok = 1'b0;
            end
            checkOutput({v.name, " wait_hold"}, {31'd0, hold_ok}, 32'd1);
            i_grant_valid = 1'b1;
            @(posedge i_clk);
            #1;
            i_grant_valid = 1'b0;
        end
        checkOutput({v.name, " valid_pulse"}, {31'd0, o_8x8out_valid}, 32'd0);

        n = 0;
        stray = 0;
        while (!o_slot_active && n < 100) begin
            if (o_config_end || o_port_grant != 8'h00) stray++;
            @(posedge i_clk);
            #1;
            n++;
        end
        checkOutput({v.name, " settle_len"}, n, 16);
        checkOutput({v.name, " settle_quiet"}, stray, 0);

        slot_len = 0;
        grant_bad = 0;
        first_grant = o_port_grant;
        while (o_slot_active && slot_len < 400) begin
            slot_len++;
            if (o_port_grant !== v.exp_grant) grant_bad++;
            if (v.abort_at > 0 && slot_len == v.abort_at) begin
                #1;
                i_rst_n = 1'b0;
                #1;
                checkOutput({v.name, " abort_slot"}, {31'd0, o_slot_active}, 32'd0);
                checkOutput({v.name, " abort_grant"}, o_port_grant, 32'h0);
                checkOutput({v.name, " abort_req"}, o_8x8out_req, 32'h0);
                stray = 0;
                for (int i = 0; i < 3; i++) begin
                    @(posedge i_clk);
                    #1;
                    if (o_config_end || o_slot_active) stray++;
                end
                @(negedge i_clk);
                i_rst_n = 1'b1;
                for (int i = 0; i < 2; i++) begin
                    @(posedge i_clk);
                    #1;
                    if (o_config_end || o_slot_active) stray++;
                end
                checkOutput({v.name, " abort_no_end"}, stray, 0);
                checkOutput({v.name, " grant_pre_abort"}, first_grant, v.exp_grant);
                return;
            end
            @(posedge i_clk);
            #1;
        end
        checkOutput({v.name, " port_grant"}, first_grant, v.exp_grant);
        checkOutput({v.name, " grant_steady"}, grant_bad, 0);
        checkOutput({v.name, " slot_len"}, slot_len, 256);
        checkOutput({v.name, " config_end"}, {31'd0, o_config_end}, 32'd1);
        @(posedge i_clk);
        #1;
        checkOutput({v.name, " end_pulse"}, {31'd0, o_config_end}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{"share_r1", 8'h11, 24'h002002, 0,  0,   24'h000002, 8'h01};
        vecs[1] = '{"share_r2", 8'h11, 24'h002002, 0,  0,   24'h002000, 8'h10};
        vecs[2] = '{"single",   8'h08, 24'h000A00, 0,  0,   24'h000A00, 8'h08};
        vecs[3] = '{"perm",     8'hFF, 24'h053977, 0,  0,   24'h053977, 8'hFF};
        vecs[4] = '{"hotspot",  8'hFF, 24'h249249, 50, 0,   24'h001000, 8'h10};
        vecs[5] = '{"abort",    8'h08, 24'h000A00, 0,  100, 24'h000A00, 8'h08};
        vecs[6] = '{"post_rst", 8'h81, 24'h400002, 0,  0,   24'h000002, 8'h01};

        #3;
        checkOutput("rst_valid", {31'd0, o_8x8out_valid}, 32'd0);
        checkOutput("rst_req", o_8x8out_req, 32'h0);
        checkOutput("rst_grant", o_port_grant, 32'h0);
        checkOutput("rst_misc", {29'd0, o_config_end, o_slot_active, o_timeout_err}, 32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // A grant while idle must not start or disturb anything.
        i_grant_valid = 1'b1;
        @(negedge i_clk);
        i_grant_valid = 1'b0;
        checkOutput("idle_grant", {30'd0, o_slot_active, o_8x8out_valid}, 32'd0);

        for (int r = 0; r < 7; r++) begin
            applyStimulus(vecs[r]);
        end

`ifdef OPTICAL_GRANT_TIMEOUT_EN
        begin
            int n;
            int stray;
            int pulses;
            @(negedge i_clk);
            i_port_req = 8'h08;
            i_port_dst = 24'h000A00;
            @(posedge i_clk);
            #1;
            i_port_req = '0;
            n = 0;
            stray = 0;
            pulses = 0;
            while (!o_timeout_err && n < 1200) begin
                if (o_config_end || o_slot_active) stray++;
                @(posedge i_clk);
                #1;
                n++;
            end
            checkOutput("timeout_len", n, 9 + 1024);
            for (int i = 0; i < 5; i++) begin
                if (o_timeout_err) pulses++;
                if (o_config_end || o_slot_active) stray++;
                @(posedge i_clk);
                #1;
            end
            checkOutput("timeout_pulse", pulses, 1);
            checkOutput("timeout_quiet", stray, 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/optical_slot_scheduler.md
Name: optical_slot_scheduler

Overview:
- Round-based scheduler that shares the 8x8 optical switch fabric among P_PORTNUM source ports.
- Each round: snapshot per-port destination requests, build a conflict-free permutation with a rotating-priority sequential matcher, and issue it to the 8x8 switch controller as a packed request with a valid.
- After the controller grants, waits out switch settling, opens a fixed data slot for matched ports, then pulses config-end back to the controller.

Parameters:
- P_DSTWIDTH, 3, destination index width.
- P_PORTNUM, 8, number of source/destination ports (2**P_DSTWIDTH).
- P_SETTLE_CYC, 16, switch settling cycles after grant (>=1).
- P_SLOT_CYC, 256, data slot length in cycles (>=1).
- P_TIMEOUT_CYC, 1024, grant wait limit (used only with the optional feature).

Ports:
- i_clk  in  1  single clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_port_req  in  P_PORTNUM  per-port request level.
- i_port_dst  in  P_DSTWIDTH*P_PORTNUM  per-port requested destination; field p at [P_DSTWIDTH*p +: P_DSTWIDTH].
- o_8x8out_req  out  P_DSTWIDTH*P_PORTNUM  permutation to the switch controller; unmatched fields are 0.
- o_8x8out_valid  out  1  one-cycle pulse qualifying o_8x8out_req.
- i_grant_valid  in  1  switch controller accepted the configuration.
- o_config_end  out  1  one-cycle pulse at end of slot.
- o_port_grant  out  P_PORTNUM  matched ports; high only during SLOT.
- o_slot_active  out  1  high during SLOT.
- o_timeout_err  out  1  one-cycle error pulse (optional feature; tied 0 otherwise).

Behaviour:
- Reset (async, i_rst_n=0): all outputs 0, state IDLE, rr_ptr=0, snapshot/match registers cleared, counters 0.
- States: IDLE, MATCH, ISSUE, WAIT_GNT, SETTLE, SLOT, END.
- IDLE: if |i_port_req, register i_port_req/i_port_dst into a snapshot, clear dst_used and match vectors, k=0, go MATCH. Inputs are ignored outside IDLE.
- MATCH: one port per cycle, p=(rr_ptr+k) mod P_PORTNUM.
  - If snap_req[p] and !dst_used[snap_dst[p]]: set match[p], set dst_used[snap_dst[p]], and write field p of the request register.
  - When k==P_PORTNUM-1, go ISSUE. MATCH always takes exactly P_PORTNUM cycles.
- ISSUE: o_8x8out_valid=1 for exactly one cycle. o_8x8out_req stays stable from ISSUE until END.
  - If i_grant_valid is seen in ISSUE, go SETTLE directly; else go WAIT_GNT.
- WAIT_GNT: hold until i_grant_valid=1, then go SETTLE. The settle counter loads at this transition.
- SETTLE: count P_SETTLE_CYC cycles, then go SLOT.
- SLOT: o_port_grant=match, o_slot_active=1 for exactly P_SLOT_CYC cycles, then go END.
- END: o_config_end=1 for one cycle; rr_ptr <= (rr_ptr+1) mod P_PORTNUM; go IDLE. A new request can be captured the following cycle.
- Latency from an IDLE request capture to o_8x8out_valid: 1+P_PORTNUM cycles.
- A grant received while not in ISSUE or WAIT_GNT is ignored.
- Counters are sized $clog2(max param)+1 and do not wrap.
- If all requests target one destination, exactly one port (the first from rr_ptr) is matched.
- Reset mid-round aborts immediately: no o_config_end is emitted and o_port_grant drops asynchronously.

Optional Feature:
- Macro: OPTICAL_GRANT_TIMEOUT_EN.
- Defined: a WAIT_GNT cycle counter runs. If P_TIMEOUT_CYC cycles elapse without i_grant_valid, pulse o_timeout_err for one cycle, advance rr_ptr, and go IDLE with no slot and no o_config_end.
- Undefined: WAIT_GNT waits indefinitely; o_timeout_err is constant 0 and the counter is not built.

Decomposition:
- Shared package optical_pkg: state enum encoding, P_DSTWIDTH/P_PORTNUM defaults, BAR/CROSS constants, field-slice helper function.
- One sub-module, optical_rr_matcher: sequential MATCH engine (snapshot, k counter, dst_used, match outputs, done flag). The FSM/timer wrapper stays in the top.

Test Plan:
- Port 3 requests dst 5, others idle.
  - o_8x8out_valid 9 cycles after capture; field 3 = 5, all other fields 0.
  - With grant in ISSUE: o_port_grant=8'h08 for 256 cycles after 16 settle cycles, then one o_config_end pulse.
- Ports 0 and 4 both request dst 2.
  - Round 1 (rr_ptr=0): port 0 matched, o_port_grant=8'h01.
  - Round 2 (rr_ptr=1): port 4 matched, o_port_grant=8'h10.
- All 8 ports request the full permutation p -> 7-p: all matched, o_port_grant=8'hFF, req fields = 7,6,...,0.
- Grant delayed 50 cycles after ISSUE: WAIT_GNT holds and o_8x8out_req stays stable; SETTLE starts the cycle after grant.
- Assert i_rst_n=0 at SLOT cycle 100: outputs 0 immediately, no o_config_end, rr_ptr=0; the next round runs normally.
- With OPTICAL_GRANT_TIMEOUT_EN, never grant: o_timeout_err pulses after 1024 WAIT_GNT cycles, FSM returns to IDLE, no o_config_end.
